// File: rtl/tile_renderer_pkg.sv
// Shared constants for the tile renderer: host write-region decode, control
// register selects and the palette commit FSM states.
package tile_renderer_pkg;

    localparam logic       REGION_MAP  = 1'b0;
    localparam logic [1:0] REGION_PAL  = 2'b10;
    localparam logic [1:0] REGION_CTRL = 2'b11;

    localparam logic [1:0] SEL_COMMIT   = 2'd0;
    localparam logic [1:0] SEL_SCROLL_X = 2'd1;
    localparam logic [1:0] SEL_SCROLL_Y = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COPY
    } pal_state_t;

endpackage

// File: rtl/tile_renderer_map_ram.sv
// Simple dual-port tile-map RAM: one write port, one registered read port.
// A read of the cell being written in the same cycle returns the old contents.
module tile_map_ram
    import tile_renderer_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/tile_renderer.sv
// Tile-map pixel renderer with a double-buffered palette committed in vblank.
// Define TILE_RENDERER_SCROLL_EN to add writable scroll_x/scroll_y registers.
module tile_renderer
    import tile_renderer_pkg::*;
#(
    parameter int CORDW      = 10,
    parameter int TILE_SHIFT = 5,
    parameter int MAP_W_BITS = 5,
    parameter int MAP_H_BITS = 5,
    parameter int IDX_W      = 4,
    parameter int COLOR_W    = 12,
    parameter int V_RES      = 480
) (
    input  logic                 clk_pix,
    input  logic                 rst,
    input  logic [CORDW-1:0]     sx,
    input  logic [CORDW-1:0]     sy,
    input  logic                 de,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 wr_en,
    input  logic [15:0]          wr_addr,
    input  logic [15:0]          wr_data,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic [COLOR_W/3-1:0] vga_r,
    output logic [COLOR_W/3-1:0] vga_g,
    output logic [COLOR_W/3-1:0] vga_b,
    output logic                 pal_busy
);

    localparam int CW     = COLOR_W / 3;
    localparam int MAP_AW = MAP_W_BITS + MAP_H_BITS;
    localparam int PAL_N  = 2 ** IDX_W;
    localparam logic [CORDW-1:0] FRAME_LINE = CORDW'(V_RES);

    logic             map_we;
    logic             pal_we;
    logic             ctrl_we;
    logic             commit;
    logic [CORDW-1:0] px;
    logic [CORDW-1:0] py;
    logic [MAP_AW-1:0] map_raddr;
    logic [IDX_W-1:0]  map_idx;
    logic              de_q;
    logic              hsync_q;
    logic              vsync_q;
    logic [COLOR_W-1:0] pix;

    pal_state_t         state;
    logic [IDX_W-1:0]   copy_idx;
    logic [COLOR_W-1:0] shadow_pal [PAL_N];
    logic [COLOR_W-1:0] active_pal [PAL_N];

    // Palette writes are refused while a commit is pending or copying so the
    // shadow copy being committed cannot change underneath the FSM.
    assign map_we  = wr_en && (wr_addr[15] == REGION_MAP);
    assign pal_we  = wr_en && (wr_addr[15:14] == REGION_PAL) && !pal_busy;
    assign ctrl_we = wr_en && (wr_addr[15:14] == REGION_CTRL);
    assign commit  = ctrl_we && (wr_addr[1:0] == SEL_COMMIT);

`ifdef TILE_RENDERER_SCROLL_EN
    logic [CORDW-1:0] scroll_x;
    logic [CORDW-1:0] scroll_y;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            scroll_x <= '0;
            scroll_y <= '0;
        end else if (ctrl_we) begin
            if (wr_addr[1:0] == SEL_SCROLL_X) begin
                scroll_x <= wr_data[CORDW-1:0];
            end
            if (wr_addr[1:0] == SEL_SCROLL_Y) begin
                scroll_y <= wr_data[CORDW-1:0];
            end
        end
    end

    assign px = sx + scroll_x;
    assign py = sy + scroll_y;
`else
    assign px = sx;
    assign py = sy;
`endif

    // Slicing the tile fields gives the modulo-map-size wrap for free.
    assign map_raddr = {px[TILE_SHIFT +: MAP_W_BITS], py[TILE_SHIFT +: MAP_H_BITS]};

    tile_map_ram #(
        .ADDR_W (MAP_AW),
        .DATA_W (IDX_W)
    ) u_map (
        .clk   (clk_pix),
        .we    (map_we),
        .waddr (wr_addr[MAP_AW-1:0]),
        .wdata (wr_data[IDX_W-1:0]),
        .raddr (map_raddr),
        .rdata (map_idx)
    );

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            de_q    <= de;
            hsync_q <= hsync_in;
            vsync_q <= vsync_in;
        end
    end

    // Commit waits for the first blanking line, then copies one entry per
    // cycle so the whole palette lands well before the next visible pixel.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state    <= IDLE;
            pal_busy <= 1'b0;
            copy_idx <= '0;
            for (int i = 0; i < PAL_N; i++) begin
                shadow_pal[i] <= '0;
                active_pal[i] <= '0;
            end
        end else begin
            if (pal_we) begin
                shadow_pal[wr_addr[IDX_W-1:0]] <= wr_data[COLOR_W-1:0];
            end
            case (state)
                IDLE: begin
                    if (commit) begin
                        state    <= PENDING;
                        pal_busy <= 1'b1;
                    end
                end
                PENDING: begin
                    if (sy == FRAME_LINE && sx == '0) begin
                        state    <= COPY;
                        copy_idx <= '0;
                    end
                end
                COPY: begin
                    active_pal[copy_idx] <= shadow_pal[copy_idx];
                    copy_idx             <= copy_idx + 1'b1;
                    if (copy_idx == '1) begin
                        state    <= IDLE;
                        pal_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    pal_busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pix = '0;
        if (de_q) begin
            pix = active_pal[map_idx];
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            vga_hsync <= hsync_q;
            vga_vsync <= vsync_q;
            vga_r     <= pix[3*CW-1:2*CW];
            vga_g     <= pix[2*CW-1:CW];
            vga_b     <= pix[CW-1:0];
        end
    end

    // Address/data bits outside the decoded fields are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{wr_addr, wr_data, px, py};

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: expected pixels are queued when the
// coordinates are driven and compared when they emerge two cycles later.
module tb_tile_renderer;

    logic        clk_pix = 1'b0;
    logic        rst;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        de;
    logic        hsync_in;
    logic        vsync_in;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        pal_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         chk;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  map_m [1024];
    logic [11:0] shadow_m [16];
    logic [11:0] active_m [16];
    logic [9:0]  scroll_x_m = '0;
    logic [9:0]  scroll_y_m = '0;

    tile_renderer #(
        .CORDW      (10),
        .TILE_SHIFT (5),
        .MAP_W_BITS (5),
        .MAP_H_BITS (5),
        .IDX_W      (4),
        .COLOR_W    (12),
        .V_RES      (480)
    ) dut (
        .clk_pix   (clk_pix),
        .rst       (rst),
        .sx        (sx),
        .sy        (sy),
        .de        (de),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .pal_busy  (pal_busy)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] expRgb(input int x, input int y, input int d);
        logic [9:0] px;
        logic [9:0] py;
        px = 10'(x) + scroll_x_m;
        py = 10'(y) + scroll_y_m;
        if (d == 0) return 12'h000;
        return active_m[map_m[{px[9:5], py[9:5]}]];
    endfunction

    task automatic applyStimulus(input int x, input int y, input int d, input int hs, input int vs, input int chk);
        exp_t e;
        sx       = 10'(x);
        sy       = 10'(y);
        de       = (d != 0);
        hsync_in = (hs != 0);
        vsync_in = (vs != 0);
        e.chk = (chk != 0);
        e.rgb = expRgb(x, y, d);
        e.hs  = (hs != 0);
        e.vs  = (vs != 0);
        exp_q.push_back(e);
        @(posedge clk_pix);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                checkOutput("pixel", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
                checkOutput("sync", 32'({vga_hsync, vga_vsync}), 32'({e.hs, e.vs}));
            end
        end
    endtask

    task automatic hostCycle(input logic [15:0] a, input logic [15:0] d, input int x, input int y, input int dd, input int chk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        applyStimulus(x, y, dd, 0, 0, chk);
        wr_en   = 1'b0;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) applyStimulus(700, 500, 0, 0, 0, 0);
    endtask

    task automatic doReset(input int n);
        rst      = 1'b1;
        wr_en    = 1'b0;
        de       = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_pix);
            #1;
        end
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        scroll_x_m = '0;
        scroll_y_m = '0;
    endtask

    // Call right after driving the boundary cycle; counts busy cycles.
    task automatic waitCopy();
        int n;
        n = pal_busy ? 1 : 0;
        for (int i = 0; i < 40 && pal_busy; i++) begin
            applyStimulus(i + 1, 481, 0, 0, 0, 0);
            if (pal_busy) n++;
        end
        checkOutput("copy_len", 32'(n), 32'd16);
        active_m = shadow_m;
    endtask

    task automatic scanRect(input int x0, input int x1, input int xs, input int y0, input int y1, input int ys);
        for (int y = y0; y <= y1; y += ys) begin
            for (int x = x0; x <= x1; x += xs) begin
                applyStimulus(x, y, 1, ((x / 16) % 3) == 0 ? 1 : 0, ((y / 16) % 2), 1);
            end
        end
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [11:0] val;
        int          v;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sx = '0; sy = '0; de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;

        doReset(3);
        checkOutput("rst_busy", 32'(pal_busy), 32'd0);
        checkOutput("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        checkOutput("rst_sync", 32'({vga_hsync, vga_vsync}), 32'd0);

        for (int c = 0; c < 1024; c++) begin
            v = (c == 65) ? 3 : int'($urandom_range(0, 15));
            hostCycle(16'(c), 16'(v), 700, 500, 0, 0);
            map_m[c] = 4'(v);
        end
        for (int i = 0; i < 16; i++) begin
            val = (i == 3) ? 12'hF00 : {4'(i), 4'(15 - i), 4'(i + 5)};
            hostCycle(16'h8000 | 16'(i), 16'(val), 700, 500, 0, 0);
            shadow_m[i] = val;
        end
        scanRect(56, 103, 4, 28, 36, 4);

        hostCycle(16'hC000, 16'h0000, 700, 500, 0, 0);
        checkOutput("busy_pending", 32'(pal_busy), 32'd1);
        blank(5);
        checkOutput("busy_hold", 32'(pal_busy), 32'd1);
        applyStimulus(0, 480, 0, 0, 0, 0);
        waitCopy();
        scanRect(56, 103, 1, 31, 33, 1);
        scanRect(56, 103, 1, 62, 64, 1);
        for (int x = 64; x < 72; x++) applyStimulus(x, 40, 0, x % 2, 1, 1);
        scanRect(0, 1023, 16, 0, 479, 16);

        // Same-cycle write and read of one cell: old value first, then new.
        hostCycle(16'd65, 16'd5, 64, 32, 1, 1);
        map_m[65] = 4'd5;
        applyStimulus(65, 32, 1, 0, 0, 1);
        hostCycle(16'd65, 16'd3, 700, 500, 0, 0);
        map_m[65] = 4'd3;

        hostCycle(16'h8005, 16'h0123, 700, 500, 0, 0);
        shadow_m[5] = 12'h123;
        hostCycle(16'hC000, 16'h0000, 700, 500, 0, 0);
        hostCycle(16'h8003, 16'h00F0, 700, 500, 0, 0);
        blank(3);
        applyStimulus(0, 480, 0, 0, 0, 0);
        waitCopy();
        scanRect(56, 103, 1, 31, 33, 1);
        scanRect(0, 1023, 16, 0, 479, 16);

        hostCycle(16'h8009, 16'h0ABC, 700, 500, 0, 0);
        shadow_m[9] = 12'hABC;
        hostCycle(16'hC000, 16'h0000, 0, 480, 0, 0);
        checkOutput("busy_boundary_commit", 32'(pal_busy), 32'd1);
        scanRect(0, 1023, 32, 0, 479, 32);
        applyStimulus(1, 480, 0, 0, 0, 0);
        blank(20);
        checkOutput("busy_frame", 32'(pal_busy), 32'd1);
        applyStimulus(0, 480, 0, 0, 0, 0);
        waitCopy();
        scanRect(0, 1023, 16, 0, 479, 16);

        hostCycle(16'hC001, 16'd1000, 700, 500, 0, 0);
        hostCycle(16'hC002, 16'd1020, 700, 500, 0, 0);
`ifdef TILE_RENDERER_SCROLL_EN
        scroll_x_m = 10'd1000;
        scroll_y_m = 10'd1020;
`endif
        scanRect(16, 48, 2, 0, 8, 2);
        scanRect(0, 1023, 16, 0, 479, 16);

        hostCycle(16'hC000, 16'h0000, 700, 500, 0, 0);
        applyStimulus(0, 480, 0, 0, 0, 0);
        blank(5);
        checkOutput("busy_mid_copy", 32'(pal_busy), 32'd1);
        doReset(1);
        checkOutput("rst_copy_busy", 32'(pal_busy), 32'd0);
        checkOutput("rst_copy_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        blank(3);
        checkOutput("rst_copy_idle", 32'(pal_busy), 32'd0);
        scanRect(0, 1023, 16, 0, 479, 16);
        blank(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
